// File: rtl/prach_buffer_mc.sv
// Multi-channel PRACH capture buffer: per-channel header queue, capture FSM and
// sample RAM, with a shared 3-cycle read port and per-channel ap_req/ap_ack.
module prach_buffer_mc #(
  parameter int NUM_CH    = 4,
  parameter int SYM_LEN   = 1536,
  parameter int MAX_SYM   = 4,
  parameter int HDR_DEPTH = 4,
  parameter int HDR_W     = 120,
  parameter int AW        = $clog2(SYM_LEN*MAX_SYM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      din_valid,
  input  logic [15:0]               din_dr,
  input  logic [15:0]               din_di,
  input  logic [7:0]                din_chn,
  input  logic [15:0]               din_sample_k,
  input  logic                      c_valid,
  output logic                      c_ready,
  input  logic [7:0]                c_chn,
  input  logic [HDR_W-1:0]          c_header,
  input  logic [19:0]               c_time_offset,
  input  logic [3:0]                c_num_symbol,
  output logic [NUM_CH-1:0]         ap_req,
  output logic [NUM_CH*HDR_W-1:0]   ap_hdr,
  input  logic [NUM_CH-1:0]         ap_ack,
  input  logic [$clog2(NUM_CH)-1:0] rd_chn,
  input  logic [AW-1:0]             rd_addr,
  input  logic                      rd_en,
  output logic [31:0]               rd_data,
  output logic [2:0]                err_flags
);

  localparam int DEPTH = SYM_LEN*MAX_SYM;
  localparam int QW    = $clog2(HDR_DEPTH);
  localparam int PW    = QW + 1;
  localparam int CW    = $clog2(NUM_CH);
  localparam int LW    = AW + 1;
  localparam logic [7:0] NUM_CH_B  = 8'(NUM_CH);
  localparam logic [3:0] MAX_SYM_B = 4'(MAX_SYM);

  typedef struct packed {
    logic [HDR_W-1:0] header;
    logic [15:0]      toff;
    logic [3:0]       nsym;
  } hdr_t;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  hdr_t             q_mem  [NUM_CH][HDR_DEPTH];
  logic [PW-1:0]    wr_ptr [NUM_CH];
  logic [PW-1:0]    rd_ptr [NUM_CH];
  logic [PW-1:0]    q_occ  [NUM_CH];
  hdr_t             head   [NUM_CH];
  state_t           state_q [NUM_CH];
  state_t           state_d [NUM_CH];
  logic [AW-1:0]    cnt_q   [NUM_CH];
  logic [AW-1:0]    cnt_d   [NUM_CH];
  logic [AW-1:0]    wr_addr [NUM_CH];
  logic [HDR_W-1:0] ap_hdr_q [NUM_CH];
  logic [31:0]      mem [NUM_CH][DEPTH];

  logic [NUM_CH-1:0] q_empty, q_full, push, pop, complete, overrun, wr_en;
  logic [NUM_CH-1:0] ap_req_q;
  logic [1:0]        err_q;
  logic              chn_ok, hdr_ok, accept, unused_toff;
  logic [CW-1:0]     c_sel;

  logic [31:0] rd_p0, rd_p1, rd_p2;
  logic        vld_p0, vld_p1;

  // The low nibble of the time offset is sub-sample resolution we do not use.
  assign unused_toff = ^c_time_offset[3:0];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      head[c]    = q_mem[c][rd_ptr[c][QW-1:0]];
      q_occ[c]   = wr_ptr[c] - rd_ptr[c];
      q_empty[c] = (wr_ptr[c] == rd_ptr[c]);
      q_full[c]  = (wr_ptr[c][QW] != rd_ptr[c][QW]) &&
                   (wr_ptr[c][QW-1:0] == rd_ptr[c][QW-1:0]);
    end
  end

  assign chn_ok  = (c_chn < NUM_CH_B);
  assign c_sel   = c_chn[CW-1:0];
  assign c_ready = chn_ok ? ~q_full[c_sel] : 1'b1;
  assign hdr_ok  = chn_ok && (c_num_symbol != 4'd0) && (c_num_symbol <= MAX_SYM_B);
  assign accept  = c_valid & c_ready;

  always_comb begin
    push = '0;
    for (int c = 0; c < NUM_CH; c++)
      push[c] = accept && hdr_ok && (c_sel == CW'(c));
  end

  always_comb begin
    logic          hit;
    logic          match;
    logic [LW-1:0] len;
    logic          last;
    wr_en    = '0;
    pop      = '0;
    complete = '0;
    overrun  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      wr_addr[c] = cnt_q[c];
      hit   = din_valid && (din_chn == 8'(c));
      match = hit && !q_empty[c] && (din_sample_k == head[c].toff);
      len   = LW'(SYM_LEN) * LW'(head[c].nsym);
      last  = ({1'b0, cnt_q[c]} == (len - LW'(1)));
      case (state_q[c])
        // IDLE also honours a match so a header that lands the cycle before its
        // first sample is not missed while the FSM is still moving to ARMED.
        IDLE, ARMED: begin
          if (match) begin
            wr_en[c]   = 1'b1;
            wr_addr[c] = '0;
            if (len == LW'(1)) begin
              complete[c] = 1'b1;
              pop[c]      = 1'b1;
              cnt_d[c]    = '0;
              state_d[c]  = DONE;
            end else begin
              cnt_d[c]   = AW'(1);
              state_d[c] = CAPTURE;
            end
          end else begin
            state_d[c] = q_empty[c] ? IDLE : ARMED;
          end
        end
        CAPTURE: begin
          if (hit) begin
            wr_en[c] = 1'b1;
            if (last) begin
              complete[c] = 1'b1;
              pop[c]      = 1'b1;
              cnt_d[c]    = '0;
              state_d[c]  = DONE;
            end else begin
              cnt_d[c] = cnt_q[c] + AW'(1);
            end
          end
        end
        DONE: begin
          // Un-acked data is protected: a new match is dropped, not captured.
          if (match) begin
            pop[c]     = 1'b1;
            overrun[c] = 1'b1;
          end
          if (ap_ack[c])
            state_d[c] = ((q_occ[c] - PW'(pop[c])) != '0) ? ARMED : IDLE;
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]  <= IDLE;
        cnt_q[c]    <= '0;
        wr_ptr[c]   <= '0;
        rd_ptr[c]   <= '0;
        ap_hdr_q[c] <= '0;
      end
      ap_req_q <= '0;
      err_q    <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PW'(1);
        if (complete[c]) begin
          ap_req_q[c] <= 1'b1;
          ap_hdr_q[c] <= head[c].header;
        end else if ((state_q[c] == DONE) && ap_ack[c]) begin
          ap_req_q[c] <= 1'b0;
        end
      end
      err_q[0] <= err_q[0] | (accept & ~hdr_ok);
      err_q[1] <= err_q[1] | (|overrun);
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c])
        q_mem[c][wr_ptr[c][QW-1:0]] <= {c_header, c_time_offset[19:4], c_num_symbol};
      if (wr_en[c])
        mem[c][wr_addr[c]] <= {din_di, din_dr};
    end
  end

  // Read stage 0: RAM access
  always_ff @(posedge clk) begin
    rd_p0 <= mem[rd_chn][rd_addr];
  end

  // Read stages 1-2: output pipeline, zeroed when no read was issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      rd_p1  <= '0;
      rd_p2  <= '0;
    end else begin
      vld_p0 <= rd_en;
      vld_p1 <= vld_p0;
      rd_p1  <= vld_p0 ? rd_p0 : '0;
      rd_p2  <= vld_p1 ? rd_p1 : '0;
    end
  end

  always_comb begin
    ap_hdr = '0;
    for (int c = 0; c < NUM_CH; c++)
      ap_hdr[c*HDR_W +: HDR_W] = ap_hdr_q[c];
  end

  assign ap_req    = ap_req_q;
  assign rd_data   = rd_p2;
  assign err_flags = {1'b0, err_q};

endmodule

// File: tb/tb_prach_buffer_mc.sv
// Bench for prach_buffer_mc: directed scenarios with random data/noise, checked
// every cycle against a transaction-level model built from queues and arrays.
module tb_prach_buffer_mc;

  localparam int NUM_CH    = 4;
  localparam int SYM_LEN   = 1536;
  localparam int MAX_SYM   = 4;
  localparam int HDR_DEPTH = 4;
  localparam int HDR_W     = 120;
  localparam int DEPTH     = SYM_LEN*MAX_SYM;
  localparam int AW        = $clog2(DEPTH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n;
  logic                    dv;
  logic [15:0]             ddr, ddi, dk;
  logic [7:0]              dchn;
  logic                    cv;
  logic                    c_ready;
  logic [7:0]              cchn;
  logic [HDR_W-1:0]        chdr;
  logic [19:0]             ctoff;
  logic [3:0]              cns;
  logic [NUM_CH-1:0]       ap_req;
  logic [NUM_CH*HDR_W-1:0] ap_hdr;
  logic [NUM_CH-1:0]       ap_ack;
  logic [1:0]              rchn;
  logic [AW-1:0]           raddr;
  logic                    ren;
  logic [31:0]             rd_data;
  logic [2:0]              err_flags;

  prach_buffer_mc #(
    .NUM_CH(NUM_CH), .SYM_LEN(SYM_LEN), .MAX_SYM(MAX_SYM),
    .HDR_DEPTH(HDR_DEPTH), .HDR_W(HDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .din_valid(dv), .din_dr(ddr), .din_di(ddi), .din_chn(dchn), .din_sample_k(dk),
    .c_valid(cv), .c_ready(c_ready), .c_chn(cchn), .c_header(chdr),
    .c_time_offset(ctoff), .c_num_symbol(cns),
    .ap_req(ap_req), .ap_hdr(ap_hdr), .ap_ack(ap_ack),
    .rd_chn(rchn), .rd_addr(raddr), .rd_en(ren), .rd_data(rd_data),
    .err_flags(err_flags)
  );

  typedef struct {
    logic [HDR_W-1:0] hdr;
    logic [15:0]      k;
    int               ns;
  } mhdr_t;

  mhdr_t             hq [NUM_CH][$];
  int                cap [NUM_CH];
  bit [NUM_CH-1:0]   pend;
  logic [HDR_W-1:0]  ehdr [NUM_CH];
  logic [2:0]        eerr;
  logic [31:0]       mm [NUM_CH][DEPTH];
  logic [31:0]       rq [$];

  bit [NUM_CH-1:0]   auto_ack, ack_user;
  bit                noise_ack;
  int                checks, errors;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      hq[c].delete();
      cap[c]  = -1;
      ehdr[c] = '0;
    end
    pend = '0;
    eerr = '0;
    rq.delete();
    rq.push_back(32'h0);
    rq.push_back(32'h0);
  endtask

  // One clock: drive acks, check c_ready, advance the model at the edge, check outputs.
  task automatic tick();
    bit [NUM_CH-1:0] a;
    bit [NUM_CH-1:0] pold;
    bit              rdy;
    mhdr_t           h;
    logic [31:0]     smp;
    a = ack_user | (auto_ack & pend);
    if (noise_ack) a = a | (4'($urandom) & ~pend);
    ap_ack = a;
    #1;
    if (int'(cchn) >= NUM_CH) rdy = 1'b1;
    else rdy = (hq[cchn[1:0]].size() < HDR_DEPTH);
    chk("c_ready", 128'(c_ready), 128'(rdy));
    @(posedge clk);
    rq.push_back(ren ? mm[rchn][raddr] : 32'h0);
    pold = pend;
    smp  = {ddi, ddr};
    for (int c = 0; c < NUM_CH; c++) begin
      if (dv && dchn == 8'(c)) begin
        if (pold[c]) begin
          if (hq[c].size() > 0 && hq[c][0].k == dk) begin
            void'(hq[c].pop_front());
            eerr[1] = 1'b1;
          end
        end else if (cap[c] >= 0) begin
          mm[c][cap[c]] = smp;
          cap[c]++;
        end else if (hq[c].size() > 0 && hq[c][0].k == dk) begin
          mm[c][0] = smp;
          cap[c]   = 1;
        end
        if (cap[c] > 0 && cap[c] == SYM_LEN*hq[c][0].ns) begin
          ehdr[c] = hq[c][0].hdr;
          void'(hq[c].pop_front());
          cap[c]  = -1;
          pend[c] = 1'b1;
        end
      end
      if (pold[c] && a[c]) pend[c] = 1'b0;
    end
    if (cv && rdy) begin
      if (int'(cchn) >= NUM_CH || cns == 4'd0 || int'(cns) > MAX_SYM) begin
        eerr[0] = 1'b1;
      end else begin
        h.hdr = chdr;
        h.k   = ctoff[19:4];
        h.ns  = int'(cns);
        hq[cchn[1:0]].push_back(h);
      end
    end
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("ap_req[%0d]", c), 128'(ap_req[c]), 128'(pend[c]));
      chk($sformatf("ap_hdr[%0d]", c), 128'(ap_hdr[c*HDR_W +: HDR_W]), 128'(ehdr[c]));
    end
    chk("err_flags", 128'(err_flags), 128'(eerr));
    if (rq.size() == 3) begin
      chk("rd_data", 128'(rd_data), 128'(rq[0]));
      void'(rq.pop_front());
    end
  endtask

  task automatic idle(input int n);
    dv = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sample(input int c, input int k);
    dv   = 1'b1;
    dchn = 8'(c);
    dk   = 16'(k);
    ddr  = 16'($urandom);
    ddi  = 16'($urandom);
    tick();
    dv = 1'b0;
  endtask

  // A cycle of traffic that never belongs to channel c (may hit a nonexistent channel).
  task automatic noise(input int c);
    dv   = 1'($urandom_range(0, 1));
    dchn = 8'((c + 1 + int'($urandom_range(0, 4))) % 6);
    dk   = 16'($urandom);
    ddr  = 16'($urandom);
    ddi  = 16'($urandom);
    tick();
    dv = 1'b0;
  endtask

  task automatic stream(input int c, input int k0, input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) noise(c);
      sample(c, k0 + i);
    end
  endtask

  task automatic push(input int c, input int k, input int ns);
    dv    = 1'b0;
    cv    = 1'b1;
    cchn  = 8'(c);
    chdr  = HDR_W'({$urandom(), $urandom(), $urandom(), $urandom()});
    ctoff = {16'(k), 4'($urandom)};
    cns   = 4'(ns);
    tick();
    cv = 1'b0;
  endtask

  task automatic readback(input int c, input int a0, input int n);
    ren  = 1'b1;
    rchn = 2'(c);
    for (int i = 0; i < n; i++) begin
      raddr = AW'(a0 + i);
      tick();
    end
    ren = 1'b0;
    idle(3);
  endtask

  initial begin
    checks = 0; errors = 0;
    dv = 0; ddr = 0; ddi = 0; dk = 0; dchn = 0;
    cv = 0; cchn = 0; chdr = '0; ctoff = 0; cns = 0;
    ap_ack = 0; rchn = 0; raddr = 0; ren = 0;
    auto_ack = 0; ack_user = 0; noise_ack = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ap_req", 128'(ap_req), 128'(0));
    chk("rst_ap_hdr", 128'(ap_hdr[127:0]), 128'(0));
    chk("rst_err", 128'(err_flags), 128'(0));
    chk("rst_rd_data", 128'(rd_data), 128'(0));
    chk("rst_c_ready", 128'(c_ready), 128'(1));
    rst_n = 1'b1;

    // ch1, one symbol from k=100, each ch1 sample followed by a ch0 sample
    push(1, 100, 1);
    for (int i = 0; i < SYM_LEN + 2; i++) begin
      sample(1, 98 + i);
      sample(0, $urandom_range(0, 65535));
    end
    idle(2);
    readback(1, 0, SYM_LEN);
    ack_user = 4'b0010;
    tick();
    ack_user = 4'b0000;
    idle(2);

    // ch0, four symbols, explicit single-cycle ack
    auto_ack = 4'b1110;
    push(0, 500, 4);
    stream(0, 500, DEPTH);
    idle(2);
    ack_user = 4'b0001;
    tick();
    ack_user = 4'b0000;
    idle(1);
    ren  = 1'b1;
    rchn = 2'd0;
    for (int i = 0; i < 64; i++) begin
      raddr = AW'($urandom_range(0, DEPTH - 1));
      tick();
    end
    ren = 1'b0;
    idle(3);

    // ch2, three back-to-back headers, prompt acks, stray acks on idle channels
    noise_ack = 1'b1;
    push(2, 10, 1);
    push(2, 20000, 1);
    push(2, 40000, 1);
    stream(2, 10, SYM_LEN);
    idle(3);
    stream(2, 20000, SYM_LEN);
    idle(3);
    stream(2, 40000, SYM_LEN);
    idle(3);
    readback(2, 0, 8);
    noise_ack = 1'b0;

    // ch3 queue full: back-pressure only on ch3, fifth header refused
    push(3, 1000, 1);
    push(3, 2000, 1);
    push(3, 3000, 1);
    push(3, 4000, 1);
    push(3, 5000, 1);
    cchn = 8'd3;
    idle(1);
    cchn = 8'd0;
    idle(1);
    cchn = 8'd3;
    stream(3, 1000, SYM_LEN);
    idle(3);

    // ch0 never acked: second header's k causes an overrun, RAM and ap_hdr preserved
    auto_ack = 4'b1110;
    push(0, 7000, 1);
    push(0, 9000, 1);
    stream(0, 7000, SYM_LEN);
    idle(2);
    sample(0, 9000);
    idle(2);
    readback(0, 0, 16);
    readback(0, SYM_LEN - 16, 16);

    // rejected headers: bad channel, zero symbols, too many symbols
    push(7, 1, 1);
    push(1, 1, 0);
    push(1, 1, 5);
    idle(2);

    // reset in the middle of a two-symbol ch1 capture
    push(1, 50, 2);
    stream(1, 50, 500);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ap_req", 128'(ap_req), 128'(0));
    chk("arst_err", 128'(err_flags), 128'(0));
    chk("arst_ap_hdr0", 128'(ap_hdr[HDR_W-1:0]), 128'(0));
    chk("arst_c_ready", 128'(c_ready), 128'(1));
    dv = 0; cv = 0; ren = 0; ap_ack = 0; cchn = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    auto_ack = 4'b1111;
    push(1, 50, 1);
    stream(1, 50, SYM_LEN);
    idle(3);
    readback(1, 0, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
